video_pattern_gen: RTL and testbench
====================================

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, visible lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch
- SYNC_POL, 1, 1 = sync pulses active-high
- COLOR_W, 8, bits per colour channel
- NUM_BARS, 8, colour bars per line (H_ACTIVE divisible by NUM_BARS)
- GRID, 32, grid pitch in pixels (power of two)
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- sys_clk  in  1  pixel clock, single clock domain
- sys_rst  in  1  asynchronous active-high reset
- enable  in  1  run timing; low = blank and hold
- mode  in  2  0 colorbar, 1 gradient, 2 grid, 3 solid
- solid_rgb  in  3*COLOR_W  colour for mode 3, {R,G,B}
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable, active pixel
- rgb  out  3*COLOR_W  pixel {R,G,B}
- frame_start  out  1  one-cycle pulse on pixel (0,0)
- pix_x  out  clog2(H_ACTIVE)  active column
- pix_y  out  clog2(V_ACTIVE)  active line

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters) and wrap to 0; v_cnt SHALL increment on each h_cnt wrap, count 0..V_TOTAL-1 and wrap to 0.
REQ-004 Line order SHALL be active, front porch, sync, back porch: active when h_cnt < H_ACTIVE; sync when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. The same ordering SHALL apply to v_cnt.
REQ-005 de SHALL equal (h active AND v active). hsync/vsync SHALL equal SYNC_POL during their sync windows and ~SYNC_POL otherwise.
REQ-006 All outputs SHALL be registered, with exactly 1 cycle of latency from the counter state to every output, so hsync, vsync, de, rgb, pix_x and pix_y stay mutually aligned.
REQ-007 frame_start SHALL be high for exactly one cycle, coincident with de for pixel (0,0).
REQ-008 The mode and solid_rgb values in use SHALL be sampled only when h_cnt=0 and v_cnt=0; a change mid-frame SHALL take effect at the next frame.
REQ-009 Mode 0 SHALL produce bar k (k = pix_x / (H_ACTIVE/NUM_BARS)) in colour index k mod 8.
- Colour order: white, yellow, cyan, green, magenta, red, blue, black.
- k SHALL come from a bar-width counter; no divider.
REQ-010 Mode 1 SHALL output R=G=B = pix_x[COLOR_W-1:0], wrapping modulo 2^COLOR_W.
REQ-011 Mode 2 SHALL output all-ones when pix_x mod GRID = 0 or pix_y mod GRID = 0, and all-zeros otherwise.
REQ-012 Mode 3 SHALL output the latched solid_rgb.
REQ-013 rgb SHALL be all-zeros whenever de=0.
REQ-014 When enable=0, the block SHALL hold h_cnt=v_cnt=0, force de=0 and frame_start=0, and drive syncs at ~SYNC_POL.
REQ-015 When enable rises, the block SHALL start from pixel (0,0), so frame_start appears 1 cycle later.

Reset
REQ-016 sys_rst SHALL asynchronously clear the counters and the latched mode (to 0) and the latched solid_rgb (to 0).
REQ-017 While sys_rst is high, outputs SHALL be: de=0, frame_start=0, rgb=0, pix_x=0, pix_y=0, hsync=vsync=~SYNC_POL.
REQ-018 Reset asserted mid-frame SHALL abort the frame; after release (with enable=1), frame_start SHALL occur 1 cycle after the first active clock edge.

Structure
REQ-019 Package video_pattern_pkg SHALL hold the mode encoding constants and the 8-entry bar colour table (at 8-bit depth; the top COLOR_W bits are used).
REQ-020 Counters and sync decode SHALL live in sub-module video_timing_ctrl, which exports h_cnt, v_cnt, the active flags and the sync flags; the pattern logic and output registers SHALL remain in the top.

Verification
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=8, V_FP=1, V_SYNC=2, V_BP=1, GRID=4, COLOR_W=8.
REQ-021 Timing: enable=1, mode=0 -> frame_start period is 288 cycles; per line, de high 16 cycles and hsync high 3 cycles starting 2 cycles after de falls; vsync high for 48 cycles.
REQ-022 Colorbar: mode=0 -> pixels x=0,1 are FFFFFF; x=2 is FFFF00; x=14,15 are 000000; rgb=0 outside de.
REQ-023 Mid-frame mode: switch from 0 to 3 (solid_rgb=123456) at line 3 -> the rest of the frame stays colorbar; the next frame is entirely 123456.
REQ-024 Grid and gradient: mode=2 -> line 1 shows FFFFFF at x=0,4,8,12 and 000000 elsewhere; lines 0 and 4 are all FFFFFF. mode=1 -> rgb at x=5 is 050505.
REQ-025 Reset and enable: assert sys_rst at line 5 -> outputs go to reset values immediately, asynchronously; after release, frame_start occurs 1 cycle after the first edge. enable=0 for 50 cycles -> de=0 and hsync=0 throughout; re-enable -> frame_start after 1 cycle.

Source files
------------

// File: rtl/video_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pattern_pkg
// Description : Shared constants for the video test-pattern generator:
//               pattern-mode encodings and the 8-entry colour-bar table
//               (8 bits per channel, packed {R,G,B}).
// Revision    : 1.0 - initial release
// ============================================================================
package video_pattern_pkg;

    localparam logic [1:0] c_MODE_COLORBAR = 2'd0;
    localparam logic [1:0] c_MODE_GRADIENT = 2'd1;
    localparam logic [1:0] c_MODE_GRID     = 2'd2;
    localparam logic [1:0] c_MODE_SOLID    = 2'd3;

    // Classic SMPTE-like bar order: white, yellow, cyan, green,
    // magenta, red, blue, black.
    localparam logic [23:0] c_BAR_COLORS [0:7] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage
`default_nettype wire

// File: rtl/video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_ctrl
// Description : Raster counters and sync/active decode. Line and frame order
//               is active, front porch, sync, back porch. Counters are held
//               at (0,0) while i_enable is low.
// Ports       : clk, rst (async, active-high), i_enable
//               o_h_cnt / o_v_cnt        - current raster position
//               o_h_active / o_v_active  - position inside the visible area
//               o_h_sync / o_v_sync      - position inside the sync window
//                                          (polarity applied by the caller)
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_ctrl #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               i_enable,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]       o_h_cnt,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]       o_v_cnt,
    output logic                                               o_h_active,
    output logic                                               o_v_active,
    output logic                                               o_h_sync,
    output logic                                               o_v_sync
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);

    localparam logic [c_HW-1:0] c_H_LAST = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_LAST = c_VW'(c_V_TOTAL - 1);

    // One extra bit so a boundary equal to the total still fits.
    localparam logic [c_HW:0] c_H_ACT_END  = (c_HW+1)'(H_ACTIVE);
    localparam logic [c_HW:0] c_H_SYNC_BEG = (c_HW+1)'(H_ACTIVE + H_FP);
    localparam logic [c_HW:0] c_H_SYNC_END = (c_HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW:0] c_V_ACT_END  = (c_VW+1)'(V_ACTIVE);
    localparam logic [c_VW:0] c_V_SYNC_BEG = (c_VW+1)'(V_ACTIVE + V_FP);
    localparam logic [c_VW:0] c_V_SYNC_END = (c_VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_HW-1:0] r_h_cnt;
    logic [c_VW-1:0] r_v_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!i_enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_h_cnt    = r_h_cnt;
    assign o_v_cnt    = r_v_cnt;
    assign o_h_active = ({1'b0, r_h_cnt} <  c_H_ACT_END);
    assign o_v_active = ({1'b0, r_v_cnt} <  c_V_ACT_END);
    assign o_h_sync   = ({1'b0, r_h_cnt} >= c_H_SYNC_BEG) && ({1'b0, r_h_cnt} < c_H_SYNC_END);
    assign o_v_sync   = ({1'b0, r_v_cnt} >= c_V_SYNC_BEG) && ({1'b0, r_v_cnt} < c_V_SYNC_END);

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_pattern_gen
// Description : Video test-pattern generator: colour bars, horizontal
//               gradient, grid and solid colour, with programmable raster
//               timing. Every output is registered one cycle after the
//               raster counter state, so all outputs stay aligned.
// Ports       : sys_clk, sys_rst (async, active-high), enable, mode,
//               solid_rgb ({R,G,B}) -> hsync, vsync, de, rgb ({R,G,B}),
//               frame_start (pixel (0,0) pulse), pix_x, pix_y
// Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1,
    parameter int COLOR_W  = 8,
    parameter int NUM_BARS = 8,
    parameter int GRID     = 32
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [3*COLOR_W-1:0]         solid_rgb,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         de,
    output logic [3*COLOR_W-1:0]         rgb,
    output logic                         frame_start,
    output logic [$clog2(H_ACTIVE)-1:0]  pix_x,
    output logic [$clog2(V_ACTIVE)-1:0]  pix_y
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_XW      = $clog2(H_ACTIVE);
    localparam int c_YW      = $clog2(V_ACTIVE);
    localparam int c_BAR_W   = H_ACTIVE / NUM_BARS;
    localparam int c_BAR_CW  = (c_BAR_W > 1) ? $clog2(c_BAR_W) : 1;

    localparam logic [c_BAR_CW-1:0] c_BAR_LAST    = c_BAR_CW'(c_BAR_W - 1);
    localparam logic [c_HW-1:0]     c_H_LAST      = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0]     c_GRID_MASK_H = c_HW'(GRID - 1);
    localparam logic [c_VW-1:0]     c_GRID_MASK_V = c_VW'(GRID - 1);

    logic [c_HW-1:0]        w_h_cnt;
    logic [c_VW-1:0]        w_v_cnt;
    logic                   w_h_active;
    logic                   w_v_active;
    logic                   w_h_sync;
    logic                   w_v_sync;

    video_timing_ctrl #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_enable   (enable),
        .o_h_cnt    (w_h_cnt),
        .o_v_cnt    (w_v_cnt),
        .o_h_active (w_h_active),
        .o_v_active (w_v_active),
        .o_h_sync   (w_h_sync),
        .o_v_sync   (w_v_sync)
    );

    logic                   w_origin;
    logic                   w_de;
    logic [1:0]             r_mode;
    logic [3*COLOR_W-1:0]   r_solid;
    logic [1:0]             w_mode_eff;
    logic [3*COLOR_W-1:0]   w_solid_eff;

    assign w_origin = (w_h_cnt == '0) && (w_v_cnt == '0);
    assign w_de     = enable & w_h_active & w_v_active;

    // Pattern settings are captured at the frame origin. The origin pixel
    // itself takes the live inputs so the whole frame uses one setting.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_mode  <= c_MODE_COLORBAR;
            r_solid <= '0;
        end else if (w_origin) begin
            r_mode  <= mode;
            r_solid <= solid_rgb;
        end
    end

    assign w_mode_eff  = w_origin ? mode      : r_mode;
    assign w_solid_eff = w_origin ? solid_rgb : r_solid;

    // Bar index tracks the current h_cnt: a bar-width counter steps a 3-bit
    // index, whose natural wrap gives the colour index k mod 8.
    logic [c_BAR_CW-1:0]    r_bar_cnt;
    logic [2:0]             r_bar_idx;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (!enable || (w_h_cnt == c_H_LAST)) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_cnt == c_BAR_LAST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_cnt <= r_bar_cnt + 1'b1;
        end
    end

    logic [23:0]            w_bar_color24;
    logic [3*COLOR_W-1:0]   w_bar_rgb;

    assign w_bar_color24 = c_BAR_COLORS[r_bar_idx];

    for (genvar i = 0; i < 3; i++) begin : g_chan
        if (COLOR_W <= 8) begin : g_narrow
            assign w_bar_rgb[i*COLOR_W +: COLOR_W] = w_bar_color24[i*8 + 8 - COLOR_W +: COLOR_W];
        end else begin : g_wide
            assign w_bar_rgb[i*COLOR_W +: COLOR_W] =
                {w_bar_color24[i*8 +: 8], {(COLOR_W-8){w_bar_color24[i*8]}}};
        end
    end

    logic [COLOR_W-1:0]     w_grad;
    logic                   w_grid_on;
    logic [3*COLOR_W-1:0]   w_pix;

    assign w_grad    = COLOR_W'(w_h_cnt);
    assign w_grid_on = ((w_h_cnt & c_GRID_MASK_H) == '0) || ((w_v_cnt & c_GRID_MASK_V) == '0);

    always_comb begin
        w_pix = '0;
        case (w_mode_eff)
            c_MODE_COLORBAR: w_pix = w_bar_rgb;
            c_MODE_GRADIENT: w_pix = {3{w_grad}};
            c_MODE_GRID:     w_pix = w_grid_on ? '1 : '0;
            c_MODE_SOLID:    w_pix = w_solid_eff;
            default:         w_pix = '0;
        endcase
    end

    logic                   r_de;
    logic                   r_frame_start;
    logic                   r_hsync;
    logic                   r_vsync;
    logic [3*COLOR_W-1:0]   r_rgb;
    logic [c_XW-1:0]        r_pix_x;
    logic [c_YW-1:0]        r_pix_y;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_rgb         <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
        end else begin
            r_de          <= w_de;
            r_frame_start <= enable & w_origin;
            r_hsync       <= (enable & w_h_sync) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (enable & w_v_sync) ? SYNC_POL : ~SYNC_POL;
            r_rgb         <= w_de ? w_pix : '0;
            r_pix_x       <= w_h_active ? c_XW'(w_h_cnt) : '0;
            r_pix_y       <= w_v_active ? c_YW'(w_v_cnt) : '0;
        end
    end

    assign de          = r_de;
    assign frame_start = r_frame_start;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb         = r_rgb;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_pattern_gen
// Description : Self-checking bench for video_pattern_gen on a tiny 24x12
//               raster. A frame-position model predicts every output each
//               cycle; directed steps pin the model with literal pixels and
//               timing measurements.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_pattern_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int GRID     = 4;
    localparam int BAR_W    = 2;
    localparam int H_TOTAL  = 24;
    localparam int FRAME    = 288;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        enable    = 1'b0;
    logic [1:0]  mode      = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        hsync, vsync, de, frame_start;
    logic [23:0] rgb;
    logic [3:0]  pix_x;
    logic [2:0]  pix_y;

    video_pattern_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (1'b1), .COLOR_W (8), .NUM_BARS (8), .GRID (GRID)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .enable      (enable),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .frame_start (frame_start),
        .pix_x       (pix_x),
        .pix_y       (pix_y)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [23:0] bars [0:7] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic logic [23:0] model_pix(input int md, input logic [23:0] sol,
                                              input int x, input int y);
        case (md)
            0:       return bars[(x / BAR_W) % 8];
            1:       return {3{x[7:0]}};
            2:       return ((x % GRID == 0) || (y % GRID == 0)) ? 24'hFFFFFF : 24'h0;
            default: return sol;
        endcase
    endfunction

    // Model state: m_pos is the raster position the DUT will output next.
    int          m_pos   = 0;
    int          m_mode  = 0;
    logic [23:0] m_solid = 24'h0;
    logic [23:0] fb [0:127];

    // Timing monitors.
    int cyc = 0, last_fs = -1, fs_period = -1;
    int de_run = 0, last_de_run = -1, de_fall_cyc = 0, hs_gap = -1;
    int hs_run = 0, last_hs_run = -1, vs_run = 0, last_vs_run = -1;
    bit de_fell = 0, prev_de = 0, prev_hs = 0, prev_vs = 0;

    always @(posedge clk) begin : compare
        bit          e_de, e_hs, e_vs, e_fs;
        logic [23:0] e_rgb;
        int          x, y;
        cyc++;
        if (rst) begin
            e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_rgb = 24'h0; x = 0; y = 0;
            m_pos = 0; m_mode = 0; m_solid = 24'h0;
        end else begin
            if (m_pos == 0) begin
                m_mode  = int'(mode);
                m_solid = solid_rgb;
            end
            x     = m_pos % H_TOTAL;
            y     = m_pos / H_TOTAL;
            e_de  = enable && (x < H_ACTIVE) && (y < V_ACTIVE);
            e_hs  = enable && (x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC);
            e_vs  = enable && (y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC);
            e_fs  = enable && (m_pos == 0);
            e_rgb = e_de ? model_pix(m_mode, m_solid, x, y) : 24'h0;
            m_pos = enable ? (m_pos + 1) % FRAME : 0;
        end
        #1;
        chk("de", de, e_de);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("frame_start", frame_start, e_fs);
        chk("rgb", rgb, e_rgb);
        if (e_de) begin
            chk("pix_x", pix_x, x);
            chk("pix_y", pix_y, y);
            fb[y * H_ACTIVE + x] = rgb;
        end
        if (frame_start) begin
            if (last_fs >= 0) fs_period = cyc - last_fs;
            last_fs = cyc;
        end
        if (de) de_run++;
        else if (prev_de) begin
            last_de_run = de_run; de_run = 0; de_fall_cyc = cyc; de_fell = 1;
        end
        if (hsync && !prev_hs) begin
            if (de_fell) hs_gap = cyc - de_fall_cyc;
            de_fell = 0;
        end
        if (hsync) hs_run++;
        else if (prev_hs) begin last_hs_run = hs_run; hs_run = 0; end
        if (vsync) vs_run++;
        else if (prev_vs) begin last_vs_run = vs_run; vs_run = 0; end
        prev_de = de; prev_hs = hsync; prev_vs = vsync;
    end

    task automatic wait_pos(input int p);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (m_pos == p) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_pos: position %0d not reached within 2000 cycles", p);
    endtask

    initial begin : stimulus
        int de_hi, hs_hi, fs_hi;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_de", de, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_rgb", rgb, 24'h0);
        chk("rst_hsync", hsync, 1'b0);
        chk("rst_vsync", vsync, 1'b0);
        chk("rst_pix_x", pix_x, 4'd0);

        // Release with enable high: frame_start on the first edge
        rst = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        chk("fs_first_edge", frame_start, 1'b1);

        // Colour-bar frame and line timing
        wait_pos(0);
        chk("bar_x0", fb[0], 24'hFFFFFF);
        chk("bar_x1", fb[1], 24'hFFFFFF);
        chk("bar_x2", fb[2], 24'hFFFF00);
        chk("bar_x14", fb[14], 24'h000000);
        chk("bar_x15", fb[15], 24'h000000);
        chk("de_run", last_de_run, 16);
        chk("hs_run", last_hs_run, 3);
        chk("hs_gap", hs_gap, 2);
        chk("vs_run", last_vs_run, 48);

        // Mode change at line 3 takes effect next frame
        wait_pos(3 * H_TOTAL);
        chk("fs_period", fs_period, FRAME);
        mode = 2'd3; solid_rgb = 24'h123456;
        wait_pos(0);
        chk("midframe_l3x0", fb[3*16 + 0], 24'hFFFFFF);
        chk("midframe_l5x2", fb[5*16 + 2], 24'hFFFF00);
        chk("midframe_l7x8", fb[7*16 + 8], 24'hFF00FF);
        chk("midframe_l7x15", fb[7*16 + 15], 24'h000000);
        wait_pos(0);
        chk("solid_first", fb[0], 24'h123456);
        chk("solid_mid", fb[4*16 + 7], 24'h123456);
        chk("solid_last", fb[127], 24'h123456);

        // Grid
        mode = 2'd2;
        wait_pos(0);
        chk("grid_l1x0", fb[16 + 0], 24'hFFFFFF);
        chk("grid_l1x4", fb[16 + 4], 24'hFFFFFF);
        chk("grid_l1x8", fb[16 + 8], 24'hFFFFFF);
        chk("grid_l1x12", fb[16 + 12], 24'hFFFFFF);
        chk("grid_l1x1", fb[16 + 1], 24'h000000);
        chk("grid_l1x5", fb[16 + 5], 24'h000000);
        chk("grid_l1x15", fb[16 + 15], 24'h000000);
        chk("grid_l0x3", fb[3], 24'hFFFFFF);
        chk("grid_l4x7", fb[4*16 + 7], 24'hFFFFFF);
        chk("grid_l2x6", fb[2*16 + 6], 24'h000000);

        // Gradient
        mode = 2'd1;
        wait_pos(0);
        chk("grad_x5", fb[5], 24'h050505);
        chk("grad_l3x15", fb[3*16 + 15], 24'h0F0F0F);

        // Asynchronous reset at line 5
        mode = 2'd0;
        wait_pos(5 * H_TOTAL + 4);
        chk("pre_reset_de", de, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_de", de, 1'b0);
        chk("async_rst_rgb", rgb, 24'h0);
        chk("async_rst_pix_x", pix_x, 4'd0);
        chk("async_rst_pix_y", pix_y, 3'd0);
        chk("async_rst_hsync", hsync, 1'b0);
        chk("async_rst_vsync", vsync, 1'b0);
        chk("async_rst_fs", frame_start, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("fs_after_reset", frame_start, 1'b1);
        chk("de_after_reset", de, 1'b1);

        // Enable low for 50 cycles mid-frame
        wait_pos(50);
        enable = 1'b0;
        de_hi = 0; hs_hi = 0; fs_hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (de) de_hi++;
            if (hsync) hs_hi++;
            if (frame_start) fs_hi++;
        end
        chk("disabled_de_count", de_hi, 0);
        chk("disabled_hs_count", hs_hi, 0);
        chk("disabled_fs_count", fs_hi, 0);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("fs_after_enable", frame_start, 1'b1);
        wait_pos(0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
